// File: rtl/irq_pkg.sv
// Shared types for the interrupt arbiter and the core-side claim controller.
// Optional build macro consumed by users of this package: IRQ_CLAIM_ROUND_ROBIN_EN.
package irq_pkg;

   localparam int NUM_INT_PORTS = 8;
   localparam int ID_W          = $clog2(NUM_INT_PORTS);

   typedef logic [ID_W-1:0] irq_id_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      NOTIFY  = 2'd1,
      SERVICE = 2'd2
   } irq_claim_state_e;

   // IDs are encoded wider than the source count when it is not a power of two.
   function automatic logic id_in_range(input irq_id_t id);
      return int'(id) < NUM_INT_PORTS;
   endfunction

endpackage

// File: rtl/irq_claim_ctrl_if.sv
// Arbiter event stream plus core claim/complete signals for irq_claim_ctrl.
// master = arbiter/core side, slave = controller side.
interface irq_claim_ctrl_if;
   import irq_pkg::*;

   logic                     IRQ_VLD;
   irq_id_t                  IRQ_ID;
   logic [NUM_INT_PORTS-1:0] IRQ_EN;
   logic                     CPU_IRQ;
   logic                     CLAIM_REQ;
   logic                     CLAIM_VLD;
   irq_id_t                  CLAIM_ID;
   logic                     CLAIM_NONE;
   logic                     CMPL_VLD;
   irq_id_t                  CMPL_ID;
   logic                     CMPL_ERR;
   logic [7:0]               COALESCE_CNT;

   modport master (
      output IRQ_VLD, IRQ_ID, IRQ_EN, CLAIM_REQ, CMPL_VLD, CMPL_ID,
      input  CPU_IRQ, CLAIM_VLD, CLAIM_ID, CLAIM_NONE, CMPL_ERR, COALESCE_CNT
   );

   modport slave (
      input  IRQ_VLD, IRQ_ID, IRQ_EN, CLAIM_REQ, CMPL_VLD, CMPL_ID,
      output CPU_IRQ, CLAIM_VLD, CLAIM_ID, CLAIM_NONE, CMPL_ERR, COALESCE_CNT
   );

endinterface

// File: rtl/irq_prio_sel.sv
// Priority pick over eligible sources; rotating from start when IRQ_CLAIM_ROUND_ROBIN_EN.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module irq_prio_sel
   import irq_pkg::*;
(
   input  logic [NUM_INT_PORTS-1:0] eligible,
`ifdef IRQ_CLAIM_ROUND_ROBIN_EN
   input  irq_id_t                  start,
`endif
   output logic                     found,
   output irq_id_t                  id
);

`ifdef IRQ_CLAIM_ROUND_ROBIN_EN
   always_comb begin
      int idx;
      found = 1'b0;
      id    = '0;
      idx   = 0;
      for (int k = 0; k < NUM_INT_PORTS; k++) begin
         idx = (int'(start) + k) % NUM_INT_PORTS;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            id    = irq_id_t'(idx);
         end
      end
   end
`else
   // Scan downward so the lowest set index is the last (winning) assignment.
   always_comb begin
      found = 1'b0;
      id    = '0;
      for (int i = NUM_INT_PORTS - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            found = 1'b1;
            id    = irq_id_t'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/irq_claim_ctrl.sv
// Pends arbiter IRQ events, raises CPU_IRQ and serves one source via claim/complete (IRQ_CLAIM_ROUND_ROBIN_EN: rotating priority).
// Latency: event -> CPU_IRQ 2 cycles; claim/complete responses 1 cycle.
// Backpressure: none; events to an already-pending source coalesce and are counted.
module irq_claim_ctrl
   import irq_pkg::*;
(
   input  logic            CLK,
   input  logic            RST,
   irq_claim_ctrl_if.slave bus
);

   logic [NUM_INT_PORTS-1:0] pending;
   logic [NUM_INT_PORTS-1:0] pending_nxt;
   logic [NUM_INT_PORTS-1:0] eligible;
   irq_id_t                  in_svc_id;
   irq_claim_state_e         state;
   irq_claim_state_e         state_nxt;
   logic [7:0]               coalesce_cnt;

   logic    found;
   irq_id_t sel_id;
   logic    ev_ok;
   logic    ev_hit;
   logic    claim_take;
   logic    cmpl_err_nxt;

   logic    cpu_irq_q;
   logic    claim_vld_q;
   logic    claim_none_q;
   irq_id_t claim_id_q;
   logic    cmpl_err_q;

   assign eligible = pending & bus.IRQ_EN;
   assign ev_ok    = bus.IRQ_VLD && id_in_range(bus.IRQ_ID);
   assign ev_hit   = ev_ok && pending[bus.IRQ_ID];

`ifdef IRQ_CLAIM_ROUND_ROBIN_EN
   irq_id_t last_id;
   irq_id_t start_id;

   assign start_id = (int'(last_id) == NUM_INT_PORTS - 1) ? '0 : last_id + irq_id_t'(1);

   always_ff @(posedge CLK) begin
      if (RST)
         last_id <= irq_id_t'(NUM_INT_PORTS - 1);
      else if (claim_take)
         last_id <= sel_id;
   end

   irq_prio_sel u_sel (
      .eligible (eligible),
      .start    (start_id),
      .found    (found),
      .id       (sel_id)
   );
`else
   irq_prio_sel u_sel (
      .eligible (eligible),
      .found    (found),
      .id       (sel_id)
   );
`endif

   // A claim arriving with a completion is answered empty; completion wins.
   always_comb begin
      state_nxt    = state;
      claim_take   = 1'b0;
      cmpl_err_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (|eligible)
               state_nxt = NOTIFY;
            if (bus.CMPL_VLD)
               cmpl_err_nxt = 1'b1;
         end
         NOTIFY: begin
            if (bus.CMPL_VLD)
               cmpl_err_nxt = 1'b1;
            if (bus.CLAIM_REQ && !bus.CMPL_VLD && found) begin
               claim_take = 1'b1;
               state_nxt  = SERVICE;
            end else if (!(|eligible)) begin
               state_nxt = IDLE;
            end
         end
         SERVICE: begin
            if (bus.CMPL_VLD) begin
               if (bus.CMPL_ID == in_svc_id)
                  state_nxt = IDLE;
               else
                  cmpl_err_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Set after clear: a same-cycle event on the claimed source keeps it pending.
   always_comb begin
      pending_nxt = pending;
      if (claim_take)
         pending_nxt[sel_id] = 1'b0;
      if (ev_ok)
         pending_nxt[bus.IRQ_ID] = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         pending      <= '0;
         in_svc_id    <= '0;
         coalesce_cnt <= '0;
         cpu_irq_q    <= 1'b0;
         claim_vld_q  <= 1'b0;
         claim_none_q <= 1'b0;
         claim_id_q   <= '0;
         cmpl_err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
         if (claim_take)
            in_svc_id <= sel_id;
         if (ev_hit && coalesce_cnt != 8'hFF)
            coalesce_cnt <= coalesce_cnt + 8'd1;
         cpu_irq_q    <= (state_nxt == NOTIFY);
         claim_vld_q  <= bus.CLAIM_REQ;
         claim_none_q <= bus.CLAIM_REQ && !claim_take;
         claim_id_q   <= claim_take ? sel_id : '0;
         cmpl_err_q   <= cmpl_err_nxt;
      end
   end

   assign bus.CPU_IRQ      = cpu_irq_q;
   assign bus.CLAIM_VLD    = claim_vld_q;
   assign bus.CLAIM_ID     = claim_id_q;
   assign bus.CLAIM_NONE   = claim_none_q;
   assign bus.CMPL_ERR     = cmpl_err_q;
   assign bus.COALESCE_CNT = coalesce_cnt;

endmodule
